// File: rtl/pwm_pkg.sv
// Shared PWM definitions so the generator and the measurer agree on duty
// width and on the capture FSM encoding.
package pwm_pkg;

  localparam int DUTY_W    = 8;
  localparam int DIV_STEPS = 8;

  typedef enum logic [1:0] {
    SEEK,
    HIGH,
    LOW
  } cap_state_e;

endpackage

// File: rtl/pwm_duty_div.sv
// Serial restoring divider: quo = floor(2^DIV_STEPS * num / den), one quotient
// bit per cycle. Requires num < den.
module pwm_duty_div
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num,
  input  logic [CNT_W-1:0]  den,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  num_q,
  output logic [CNT_W-1:0]  den_q,
  output logic [DUTY_W-1:0] quo
);

  localparam int STEP_W = $clog2(DIV_STEPS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DIV_STEPS - 1);

  logic [CNT_W:0]    rem;
  logic [CNT_W:0]    rem_in;
  logic [CNT_W:0]    rem_dbl;
  logic [CNT_W:0]    rem_nxt;
  logic [CNT_W:0]    den_ext;
  logic              q_bit;
  logic [STEP_W-1:0] step_cnt;

  // The first iteration runs in the launch cycle straight from the inputs, so
  // the last quotient bit is ready in time for valid 9 cycles after rise_p.
  always_comb begin
    rem_in  = start ? {1'b0, num} : rem;
    den_ext = start ? {1'b0, den} : {1'b0, den_q};
    rem_dbl = rem_in << 1;
    q_bit   = (rem_dbl >= den_ext);
    rem_nxt = q_bit ? (rem_dbl - den_ext) : rem_dbl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      num_q    <= '0;
      den_q    <= '0;
      quo      <= '0;
      rem      <= '0;
      step_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every register in this block
      // sees the pre-edge values of the others regardless of statement order.
      done <= 1'b0;
      if (abort) begin
        busy <= 1'b0;
      end else if (start) begin
        num_q    <= num;
        den_q    <= den;
        rem      <= rem_nxt;
        quo      <= {{(DUTY_W-1){1'b0}}, q_bit};
        step_cnt <= {{(STEP_W-1){1'b0}}, 1'b1};
        busy     <= 1'b1;
      end else if (busy) begin
        rem      <= rem_nxt;
        quo      <= {quo[DUTY_W-2:0], q_bit};
        step_cnt <= step_cnt + 1'b1;
        if (step_cnt == LAST_STEP) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_meas.sv
// PWM receiver: synchronises pwm_in, measures high time and period in clk
// cycles and reports duty = floor(256*high/period) with a one-cycle valid.
module pwm_meas
  import pwm_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic [DUTY_W-1:0] duty,
  output logic              valid,
  output logic              signal_lost,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pin_s;
  logic                   prev_q;
  logic                   rise_p;
  logic                   fall_p;
  logic [CNT_W-1:0]       cnt;
  logic                   cnt_sat;
  logic [CNT_W-1:0]       h_cap;
  cap_state_e             state_q;
  cap_state_e             state_d;
  logic                   timeout;
  logic                   launch_req;
  logic                   cap_h;
  logic                   div_busy;
  logic                   div_done;
  logic [CNT_W-1:0]       div_num;
  logic [CNT_W-1:0]       div_den;
  logic [DUTY_W-1:0]      div_quo;

  // Synchroniser and edge history reset high: a pin already high at reset
  // release must not look like a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      prev_q <= pin_s;
    end
  end

  assign pin_s   = sync_q[SYNC_STAGES-1];
  assign rise_p  = pin_s & ~prev_q;
  assign fall_p  = ~pin_s & prev_q;
  assign cnt_sat = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt <= '0;
    else if (!ena)     cnt <= '0;
    else if (rise_p)   cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
    else if (!cnt_sat) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SEEK;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a signal
    // unassigned and no latch is inferred.
    state_d    = state_q;
    timeout    = 1'b0;
    launch_req = 1'b0;
    cap_h      = 1'b0;
    if (!ena) begin
      state_d = SEEK;
    end else begin
      case (state_q)
        SEEK: if (rise_p) state_d = HIGH;
        HIGH: begin
          if (cnt_sat) begin
            state_d = SEEK;
            timeout = 1'b1;
          end else if (fall_p) begin
            state_d = LOW;
            cap_h   = 1'b1;
          end
        end
        LOW: begin
          // A rise in the saturating cycle still closes a valid period.
          if (rise_p) begin
            state_d    = HIGH;
            launch_req = 1'b1;
          end else if (cnt_sat) begin
            state_d = SEEK;
            timeout = 1'b1;
          end
        end
        default: state_d = SEEK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     h_cap <= '0;
    else if (cap_h) h_cap <= cnt;
  end

  pwm_duty_div #(
    .CNT_W(CNT_W)
  ) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .start(launch_req & ~div_busy),
    .abort(timeout | ~ena),
    .num  (h_cap),
    .den  (cnt),
    .busy (div_busy),
    .done (div_done),
    .num_q(div_num),
    .den_q(div_den),
    .quo  (div_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period      <= '0;
      high_time   <= '0;
      duty        <= '0;
      valid       <= 1'b0;
      signal_lost <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      valid   <= 1'b0;
      overrun <= 1'b0;
      if (!ena) begin
        signal_lost <= 1'b0;
      end else begin
        if (timeout) begin
          valid     <= 1'b1;
          period    <= '0;
          high_time <= '0;
          duty      <= pin_s ? '1 : '0;
        end else if (div_done) begin
          valid     <= 1'b1;
          period    <= div_den;
          high_time <= div_num;
          duty      <= div_quo;
        end
        if (rise_p)       signal_lost <= 1'b0;
        else if (timeout) signal_lost <= 1'b1;
        overrun <= launch_req & div_busy;
      end
    end
  end

endmodule

// File: tb/tb_pwm_meas.sv
// Self-checking bench for pwm_meas: table vectors, random waveforms against a
// timestamp-based reference model, and hand-written corner sequences.
module tb_pwm_meas;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 9;  // pin rise (driven) -> valid visible

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic pin = 1'b0;
  logic pin8 = 1'b0;

  logic [15:0] period, high_time;
  logic [7:0]  duty;
  logic        valid, signal_lost, overrun;
  logic [7:0]  period8, high8, duty8;
  logic        valid8, lost8, ovr8;

  pwm_meas #(.CNT_W(16), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .pwm_in(pin),
    .period(period), .high_time(high_time), .duty(duty),
    .valid(valid), .signal_lost(signal_lost), .overrun(overrun));

  pwm_meas #(.CNT_W(8), .SYNC_STAGES(SYNC)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .pwm_in(pin8),
    .period(period8), .high_time(high8), .duty(duty8),
    .valid(valid8), .signal_lost(lost8), .overrun(ovr8));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; int p; int h; int d; } ev_t;
  typedef struct { int h; int l; int n; int exp_p; int exp_h; int exp_d; } vec_t;

  ev_t got_q[$];
  ev_t got8_q[$];
  int  ovr_cnt = 0;

  always @(negedge clk) begin : mon
    ev_t e;
    if (valid) begin
      e.c = cyc; e.p = int'(period); e.h = int'(high_time); e.d = int'(duty);
      got_q.push_back(e);
    end
    if (valid8) begin
      e.c = cyc; e.p = int'(period8); e.h = int'(high8); e.d = int'(duty8);
      got8_q.push_back(e);
    end
    if (overrun) ovr_cnt = ovr_cnt + 1;
  end

  int total = 0;
  int bad = 0;
  int rise_q[$];
  int fall_q[$];

  task automatic check(input string name, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tick(2);
    check("reset outputs", {period, high_time, duty, valid, signal_lost, overrun}, 0);
    check("reset outputs w8", {period8, high8, duty8, valid8, lost8, ovr8}, 0);
    rst_n = 1'b1;
  endtask

  // Called at a negedge; leaves the pin low at the end of the period.
  task automatic drive_period(input int h, input int l);
    pin = 1'b1;
    rise_q.push_back(cyc);
    tick(h);
    pin = 1'b0;
    fall_q.push_back(cyc);
    tick(l);
  endtask

  task automatic compare_list(input string tag, input int mark, input ev_t exp_q[$], input bit use8);
    int n_got;
    ev_t g;
    n_got = (use8 ? got8_q.size() : got_q.size()) - mark;
    check({tag, " valid count"}, n_got, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n_got; i++) begin
      g = use8 ? got8_q[mark+i] : got_q[mark+i];
      check($sformatf("%s[%0d] cycle", tag, i), g.c, exp_q[i].c);
      check($sformatf("%s[%0d] period", tag, i), g.p, exp_q[i].p);
      check($sformatf("%s[%0d] high_time", tag, i), g.h, exp_q[i].h);
      check($sformatf("%s[%0d] duty", tag, i), g.d, exp_q[i].d);
    end
  endtask

  // Reference model: each pair of consecutive pin rises is one measurement.
  task automatic compare_chain(input string tag, input int mark);
    ev_t exp_q[$];
    ev_t e;
    for (int i = 0; i + 1 < rise_q.size(); i++) begin
      e.p = rise_q[i+1] - rise_q[i];
      e.h = fall_q[i] - rise_q[i];
      e.d = (e.h * 256) / e.p;
      e.c = rise_q[i+1] + LAT;
      exp_q.push_back(e);
    end
    compare_list(tag, mark, exp_q, 1'b0);
  endtask

  function automatic ev_t mk(input int c, input int p, input int h, input int d);
    ev_t e;
    e.c = c; e.p = p; e.h = h; e.d = d;
    return e;
  endfunction

  initial begin
    vec_t vecs[$];
    ev_t  exp_q[$];
    int   mark, ovr_base, r1, r2, rb, rc, rf, ry, h, l;

    vecs.push_back('{30, 70, 3, 100, 30, 76});
    vecs.push_back('{1, 255, 2, 256, 1, 1});
    vecs.push_back('{255, 1, 2, 256, 255, 255});
    vecs.push_back('{20, 20, 2, 40, 20, 128});
    vecs.push_back('{5, 4, 3, 9, 5, 142});
    vecs.push_back('{50, 50, 2, 100, 50, 128});

    // Table vectors: each from reset, n full periods closed by a final rise.
    foreach (vecs[k]) begin
      pin = 1'b0;
      do_reset();
      tick(5);
      rise_q.delete(); fall_q.delete();
      mark = got_q.size();
      ovr_base = ovr_cnt;
      for (int i = 0; i < vecs[k].n; i++) drive_period(vecs[k].h, vecs[k].l);
      pin = 1'b1;
      rise_q.push_back(cyc);
      tick(LAT + 3);
      compare_chain($sformatf("vec%0d", k), mark);
      check($sformatf("vec%0d period", k), period, vecs[k].exp_p);
      check($sformatf("vec%0d high_time", k), high_time, vecs[k].exp_h);
      check($sformatf("vec%0d duty", k), duty, vecs[k].exp_d);
      check($sformatf("vec%0d overrun", k), ovr_cnt - ovr_base, 0);
    end

    // Random continuous waveform, every period at least 9 cycles.
    pin = 1'b0;
    do_reset();
    tick(5);
    rise_q.delete(); fall_q.delete();
    mark = got_q.size();
    ovr_base = ovr_cnt;
    for (int i = 0; i < 25; i++) begin
      h = $urandom_range(1, 150);
      l = $urandom_range(1, 150);
      if (h + l < 9) l = 9 - h;
      drive_period(h, l);
    end
    pin = 1'b1;
    rise_q.push_back(cyc);
    tick(LAT + 3);
    compare_chain("random", mark);
    check("random overrun", ovr_cnt - ovr_base, 0);

    // Timeout on the 8-bit instance: stuck high, then recovery, then stuck low.
    pin8 = 1'b0;
    do_reset();
    tick(5);
    mark = got8_q.size();
    pin8 = 1'b1;
    r1 = cyc;
    tick(300);
    exp_q.delete();
    exp_q.push_back(mk(r1 + SYNC + 256, 0, 0, 255));
    compare_list("timeout high", mark, exp_q, 1'b1);
    check("signal_lost set", lost8, 1);
    mark = got8_q.size();
    pin8 = 1'b0;
    tick(10);
    pin8 = 1'b1;
    tick(SYNC);
    check("signal_lost before rise_p", lost8, 1);
    tick(1);
    check("signal_lost cleared", lost8, 0);
    tick(10 - SYNC - 1);
    pin8 = 1'b0;
    tick(10);
    pin8 = 1'b1;
    r2 = cyc;
    tick(10);
    pin8 = 1'b0;
    tick(300);
    exp_q.delete();
    exp_q.push_back(mk(r2 + LAT, 20, 10, 128));
    exp_q.push_back(mk(r2 + SYNC + 256, 0, 0, 0));
    compare_list("recover+timeout low", mark, exp_q, 1'b1);
    check("signal_lost low stuck", lost8, 1);

    // Periods shorter than the divider: overruns, reported values stay right.
    pin = 1'b0;
    do_reset();
    tick(5);
    mark = got_q.size();
    ovr_base = ovr_cnt;
    for (int i = 0; i < 20; i++) drive_period(1, 2);
    tick(20);
    check("short period overrun seen", (ovr_cnt - ovr_base) > 0, 1);
    check("short period valid seen", (got_q.size() - mark) > 0, 1);
    for (int i = mark; i < got_q.size(); i++)
      check($sformatf("short[%0d] p/h/d", i - mark),
            {got_q[i].p, got_q[i].h, got_q[i].d}, {32'd3, 32'd1, 32'd85});

    // ena dropped mid-HIGH: in-flight divide discarded, outputs held.
    pin = 1'b0;
    do_reset();
    tick(5);
    mark = got_q.size();
    drive_period(10, 30);
    rb = cyc;
    drive_period(10, 30);
    rc = cyc;
    drive_period(10, 30);
    pin = 1'b1;
    tick(4);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check($sformatf("ena off hold %0d", i), {valid, period, high_time, duty},
            {1'b0, 16'd40, 16'd10, 8'd64});
    end
    ena = 1'b1;
    tick(11);
    pin = 1'b0;
    tick(20);
    drive_period(20, 20);
    pin = 1'b1;
    rf = cyc;
    tick(20);
    pin = 1'b0;
    tick(LAT);
    exp_q.delete();
    exp_q.push_back(mk(rb + LAT, 40, 10, 64));
    exp_q.push_back(mk(rc + LAT, 40, 10, 64));
    exp_q.push_back(mk(rf + LAT, 40, 20, 128));
    compare_list("ena drop", mark, exp_q, 1'b0);

    // Reset mid-divide with the pin held high across release.
    mark = got_q.size();
    pin = 1'b1;
    tick(5);
    rst_n = 1'b0;
    tick(2);
    check("mid-divide reset outputs", {period, high_time, duty, valid, signal_lost, overrun}, 0);
    rst_n = 1'b1;
    tick(20);
    check("no valid after release", got_q.size() - mark, 0);
    check("outputs after release", {period, high_time, duty}, 0);
    pin = 1'b0;
    tick(20);
    pin = 1'b1;
    tick(10);
    pin = 1'b0;
    tick(20);
    pin = 1'b1;
    ry = cyc;
    tick(LAT + 2);
    exp_q.delete();
    exp_q.push_back(mk(ry + LAT, 30, 10, 85));
    compare_list("after reset", mark, exp_q, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
